// File: rtl/fft_iter_pkg.sv
// Bank-state encoding shared by the FFT bank scheduler and its helpers.
// Pure declarations: no latency, no flow control.
package fft_iter_pkg;
  localparam int BANK_STATE_WL = 3;

  localparam logic [BANK_STATE_WL-1:0] ST_FREE  = 3'd0;
  localparam logic [BANK_STATE_WL-1:0] ST_FILL  = 3'd1;
  localparam logic [BANK_STATE_WL-1:0] ST_FULL  = 3'd2;
  localparam logic [BANK_STATE_WL-1:0] ST_CALC  = 3'd3;
  localparam logic [BANK_STATE_WL-1:0] ST_DONE  = 3'd4;
  localparam logic [BANK_STATE_WL-1:0] ST_DRAIN = 3'd5;
endpackage

// File: rtl/fft_frame_counter.sv
// Frame index counter: advances on inc, wraps to 0 after LAST; last is combinational.
// One-cycle update latency; the caller gates inc, so no backpressure of its own.
module fft_frame_counter #(
  parameter int AddrWL = 5,
  parameter int LAST   = 31
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              inc,
  output logic [AddrWL-1:0] cnt,
  output logic              last
);
  localparam logic [AddrWL-1:0] LastIdx = AddrWL'(LAST);

  assign last = (cnt == LastIdx);

  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= last ? '0 : cnt + AddrWL'(1);
    end
  end
endmodule

// File: rtl/fft_iter_bank_sched.sv
// Ping-pong bank scheduler: two RAM banks rotate through load, FFT run and unload roles.
// Start pulse 1 cycle after the last sample; IN_READY drops while the fill bank is occupied.
module fft_iter_bank_sched
  import fft_iter_pkg::*;
#(
  parameter int N_POINTS = 32,
  parameter int AddrWL   = 5,
  parameter bit BITREV   = 1'b1
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              EN,
  input  logic              IN_VALID,
  output logic              IN_READY,
  output logic              IN_BANK,
  output logic [AddrWL-1:0] IN_ADDR,
  output logic              IN_WE,
  output logic              FFT_START,
  input  logic              FFT_BUSY,
  output logic              FFT_BANK,
  output logic              OUT_VALID,
  input  logic              OUT_READY,
  output logic              OUT_BANK,
  output logic [AddrWL-1:0] OUT_ADDR,
  output logic              OUT_LAST
);
  logic [BANK_STATE_WL-1:0] bank_state [2];
  logic                     fill_ptr, calc_ptr, out_ptr;
  logic                     pending, busy_seen, fft_start_q;
  logic [AddrWL-1:0]        in_cnt, out_cnt;
  logic                     in_last, out_last;
  logic                     in_open, out_open, in_hs, out_hs;
  logic                     start_go, calc_done;

  function automatic logic [AddrWL-1:0] bitrev(input logic [AddrWL-1:0] a);
    logic [AddrWL-1:0] r;
    for (int i = 0; i < AddrWL; i++) r[i] = a[AddrWL-1-i];
    return r;
  endfunction

  assign in_open  = (bank_state[fill_ptr] == ST_FREE) || (bank_state[fill_ptr] == ST_FILL);
  assign out_open = (bank_state[out_ptr] == ST_DONE) || (bank_state[out_ptr] == ST_DRAIN);

  assign IN_READY = EN & ~RST & in_open;
  assign in_hs    = IN_VALID & IN_READY;
  assign IN_WE    = in_hs;
  assign IN_BANK  = fill_ptr;
  assign IN_ADDR  = BITREV ? bitrev(in_cnt) : in_cnt;

  assign OUT_VALID = EN & ~RST & out_open;
  assign out_hs    = OUT_VALID & OUT_READY;
  assign OUT_BANK  = out_ptr;
  assign OUT_ADDR  = out_cnt;
  assign OUT_LAST  = OUT_VALID & out_last;

  // Busy detection is level-based, so a BUSY fall during EN=0 is taken on the next enabled edge.
  assign start_go  = EN & (bank_state[calc_ptr] == ST_FULL) & ~FFT_BUSY & ~pending;
  assign calc_done = EN & busy_seen & ~FFT_BUSY;
  assign FFT_START = fft_start_q;
  assign FFT_BANK  = calc_ptr;

  fft_frame_counter #(.AddrWL(AddrWL), .LAST(N_POINTS - 1)) u_in_cnt (
    .CLK  (CLK),
    .RST  (RST),
    .inc  (in_hs),
    .cnt  (in_cnt),
    .last (in_last)
  );

  fft_frame_counter #(.AddrWL(AddrWL), .LAST(N_POINTS - 1)) u_out_cnt (
    .CLK  (CLK),
    .RST  (RST),
    .inc  (out_hs),
    .cnt  (out_cnt),
    .last (out_last)
  );

  // Each role only ever touches a bank in its own states, so the updates below never collide.
  always_ff @(posedge CLK) begin
    if (RST) begin
      bank_state[0] <= ST_FREE;
      bank_state[1] <= ST_FREE;
      fill_ptr      <= 1'b0;
      calc_ptr      <= 1'b0;
      out_ptr       <= 1'b0;
      pending       <= 1'b0;
      busy_seen     <= 1'b0;
      fft_start_q   <= 1'b0;
    end else begin
      fft_start_q <= start_go;
      if (EN) begin
        if (in_hs) begin
          bank_state[fill_ptr] <= in_last ? ST_FULL : ST_FILL;
          if (in_last) fill_ptr <= ~fill_ptr;
        end
        if (start_go) begin
          bank_state[calc_ptr] <= ST_CALC;
          pending              <= 1'b1;
        end
        if (pending && FFT_BUSY) busy_seen <= 1'b1;
        if (calc_done) begin
          bank_state[calc_ptr] <= ST_DONE;
          pending              <= 1'b0;
          busy_seen            <= 1'b0;
          calc_ptr             <= ~calc_ptr;
        end
        if (out_hs) begin
          bank_state[out_ptr] <= out_last ? ST_FREE : ST_DRAIN;
          if (out_last) out_ptr <= ~out_ptr;
        end
      end
    end
  end
endmodule

// File: tb/tb_fft_iter_bank_sched.sv
// Directed bench for the ping-pong FFT bank scheduler; core BUSY is modelled by hand.
module tb_fft_iter_bank_sched;
  logic       CLK = 1'b0;
  logic       RST, EN, IN_VALID, FFT_BUSY, OUT_READY;
  logic       IN_READY, IN_BANK, IN_WE, FFT_START, FFT_BANK, OUT_VALID, OUT_BANK, OUT_LAST;
  logic [4:0] IN_ADDR, OUT_ADDR;

  int total = 0;
  int bad   = 0;
  int brv [32] = '{0, 16, 8, 24, 4, 20, 12, 28, 2, 18, 10, 26, 6, 22, 14, 30,
                   1, 17, 9, 25, 5, 21, 13, 29, 3, 19, 11, 27, 7, 23, 15, 31};

  fft_iter_bank_sched #(.N_POINTS(32), .AddrWL(5), .BITREV(1'b1)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .EN        (EN),
    .IN_VALID  (IN_VALID),
    .IN_READY  (IN_READY),
    .IN_BANK   (IN_BANK),
    .IN_ADDR   (IN_ADDR),
    .IN_WE     (IN_WE),
    .FFT_START (FFT_START),
    .FFT_BUSY  (FFT_BUSY),
    .FFT_BANK  (FFT_BANK),
    .OUT_VALID (OUT_VALID),
    .OUT_READY (OUT_READY),
    .OUT_BANK  (OUT_BANK),
    .OUT_ADDR  (OUT_ADDR),
    .OUT_LAST  (OUT_LAST)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    RST = 1'b1; EN = 1'b1; IN_VALID = 1'b0; FFT_BUSY = 1'b0; OUT_READY = 1'b0;
    cyc(); cyc();
    chk("rst_in_ready", IN_READY, 0);
    chk("rst_out_valid", OUT_VALID, 0);
    chk("rst_fft_start", FFT_START, 0);
    chk("rst_in_we", IN_WE, 0);
    chk("rst_in_addr", IN_ADDR, 0);
    RST = 1'b0; #1;
    chk("post_rst_in_ready", IN_READY, 1);
    chk("post_rst_banks", {IN_BANK, FFT_BANK, OUT_BANK}, 0);
    chk("post_rst_out_addr", OUT_ADDR, 0);
    chk("post_rst_out_last", OUT_LAST, 0);

    // Frame 0 into bank 0, bit-reversed addresses.
    IN_VALID = 1'b1; #1;
    for (int i = 0; i < 32; i++) begin
      chk($sformatf("f0_addr%0d", i), IN_ADDR, brv[i]);
      chk("f0_we", IN_WE, 1);
      chk("f0_bank", IN_BANK, 0);
      cyc();
    end
    IN_VALID = 1'b0; #1;
    chk("f0_start_not_yet", FFT_START, 0);
    chk("f0_fill_toggle", IN_BANK, 1);
    chk("f0_bank1_ready", IN_READY, 1);
    cyc();
    chk("f0_start_pulse", FFT_START, 1);
    chk("f0_fft_bank", FFT_BANK, 0);
    FFT_BUSY = 1'b1;
    cyc();
    chk("f0_start_one_cycle", FFT_START, 0);
    repeat (98) cyc();
    chk("f0_busy_no_out", OUT_VALID, 0);
    FFT_BUSY = 1'b0; #1;
    chk("f0_busy_fall_same_cycle", OUT_VALID, 0);
    cyc();
    chk("f0_done_out_valid", OUT_VALID, 1);
    chk("f0_out_bank", OUT_BANK, 0);
    chk("f0_calc_toggle", FFT_BANK, 1);

    OUT_READY = 1'b1; #1;
    for (int j = 0; j < 32; j++) begin
      chk($sformatf("f0_oaddr%0d", j), OUT_ADDR, j);
      chk("f0_olast", OUT_LAST, (j == 31) ? 1 : 0);
      cyc();
    end
    OUT_READY = 1'b0; #1;
    chk("f0_freed_out_valid", OUT_VALID, 0);
    chk("f0_out_toggle", OUT_BANK, 1);
    chk("f0_out_addr_wrap", OUT_ADDR, 0);

    // Fresh start: bank 0 filled with an EN pause at in_cnt=7.
    RST = 1'b1; cyc(); RST = 1'b0;
    IN_VALID = 1'b1; #1;
    for (int i = 0; i < 32; i++) begin
      if (i == 7) begin
        EN = 1'b0; #1;
        repeat (5) begin
          chk("en0_in_ready", IN_READY, 0);
          chk("en0_in_we", IN_WE, 0);
          chk("en0_in_addr_hold", IN_ADDR, 28);
          cyc();
        end
        EN = 1'b1; #1;
      end
      chk($sformatf("f1_addr%0d", i), IN_ADDR, brv[i]);
      chk("f1_we", IN_WE, 1);
      cyc();
    end

    // Bank 1 fills while bank 0 computes; last write and BUSY fall share one edge.
    for (int k = 0; k < 32; k++) begin
      FFT_BUSY = (k >= 1 && k <= 30); #1;
      chk("f2_bank", IN_BANK, 1);
      chk($sformatf("f2_addr%0d", k), IN_ADDR, brv[k]);
      chk("f2_we", IN_WE, 1);
      if (k == 1) begin
        chk("f2_start_b0", FFT_START, 1);
        chk("f2_fft_bank0", FFT_BANK, 0);
      end
      if (k == 2) chk("f2_start_low", FFT_START, 0);
      cyc();
    end
    chk("same_edge_out_valid", OUT_VALID, 1);
    chk("same_edge_out_bank", OUT_BANK, 0);
    chk("same_edge_calc_toggle", FFT_BANK, 1);
    chk("same_edge_fill_toggle", IN_BANK, 0);
    chk("full_stall_ready", IN_READY, 0);
    chk("full_stall_we", IN_WE, 0);
    chk("b1_start_not_yet", FFT_START, 0);
    cyc();
    chk("b1_start_pulse", FFT_START, 1);
    chk("b1_fft_bank", FFT_BANK, 1);
    FFT_BUSY = 1'b1;
    repeat (3) begin
      cyc();
      chk("third_frame_stall", IN_READY, 0);
    end

    // Drain bank 0 with an EN pause; bank 1 BUSY falls during the pause.
    OUT_READY = 1'b1; #1;
    for (int j = 0; j < 32; j++) begin
      if (j == 10) begin
        EN = 1'b0; FFT_BUSY = 1'b0; #1;
        repeat (5) begin
          chk("en0_out_valid", OUT_VALID, 0);
          chk("en0_out_addr_hold", OUT_ADDR, 10);
          chk("en0_fft_bank_hold", FFT_BANK, 1);
          chk("en0_no_start", FFT_START, 0);
          cyc();
        end
        EN = 1'b1; #1;
      end
      if (j == 11) chk("busy_fall_after_en", FFT_BANK, 0);
      chk("d0_out_valid", OUT_VALID, 1);
      chk($sformatf("d0_oaddr%0d", j), OUT_ADDR, j);
      chk("d0_out_bank", OUT_BANK, 0);
      cyc();
    end

    // Third frame into freed bank 0 while bank 1 drains; both finish on one edge.
    for (int i = 0; i < 32; i++) begin
      chk("f3_bank", IN_BANK, 0);
      chk($sformatf("f3_addr%0d", i), IN_ADDR, brv[i]);
      chk("d1_out_bank", OUT_BANK, 1);
      chk($sformatf("d1_oaddr%0d", i), OUT_ADDR, i);
      chk("d1_olast", OUT_LAST, (i == 31) ? 1 : 0);
      cyc();
    end
    IN_VALID = 1'b0; OUT_READY = 1'b0; #1;
    chk("f3_empty", OUT_VALID, 0);
    chk("f3_fill_toggle", IN_BANK, 1);
    chk("f3_ready_b1", IN_READY, 1);
    chk("f3_out_toggle", OUT_BANK, 0);
    chk("f3_start_not_yet", FFT_START, 0);
    cyc();
    chk("f3_start_pulse", FFT_START, 1);
    chk("f3_fft_bank", FFT_BANK, 0);
    FFT_BUSY = 1'b1;
    repeat (3) cyc();

    // Reset mid-compute.
    RST = 1'b1; #1;
    chk("rst_mid_in_ready", IN_READY, 0);
    chk("rst_mid_out_valid", OUT_VALID, 0);
    cyc();
    RST = 1'b0; FFT_BUSY = 1'b0; #1;
    chk("rst2_in_ready", IN_READY, 1);
    chk("rst2_banks", {IN_BANK, FFT_BANK, OUT_BANK}, 0);
    chk("rst2_addrs", {IN_ADDR, OUT_ADDR}, 0);
    chk("rst2_start", FFT_START, 0);
    chk("rst2_out_valid", OUT_VALID, 0);
    IN_VALID = 1'b1; #1;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("f4_addr%0d", i), IN_ADDR, brv[i]);
      chk("f4_bank", IN_BANK, 0);
      cyc();
    end
    IN_VALID = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
